i2c_slave_regs: RTL and testbench

I2C target (slave) with a small byte-wide register file, responding at a fixed 7-bit address. It is the bus-side counterpart of the on-board Wishbone/I2C master sequencer: it answers that master's address phase, write bursts (pointer then data) and repeated-start reads (1–N bytes, ACK/NACK terminated). Registers are exported in parallel to fabric logic, and a per-write strobe is raised on each data byte.

---
 rtl/i2c_slave_regs.sv | 186 ++++++++++++++++++
 tb/tb_i2c_slave_regs.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regs.sv
// I2C target at a fixed 7-bit address fronting a byte-wide register file with write strobes.
// Define I2C_SLV_GLITCH_FILTER_EN to add a 3-sample spike filter on SCL/SDA.
module i2c_slave_regs #(
    parameter logic [6:0] I2C_ADDR = 7'h57,
    parameter int         NREG     = 8,
    localparam int        PW       = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe,
    output logic [8*NREG-1:0] regs_flat,
    output logic              wr_pulse,
    output logic [PW-1:0]     wr_idx,
    output logic              busy
);

    // state  | meaning
    // IDLE   | wait for START       ADDR  | address byte     PTR    | pointer byte
    // WDATA  | write data bytes     RDATA | drive read data  IGNORE | not addressed
    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR, ST_PTR, ST_WDATA, ST_RDATA, ST_IGNORE
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_scl_sync, r_sda_sync;
    logic            w_scl_s, w_sda_s;
    logic            r_scl_d, r_sda_d;
    logic [6:0]      r_shift;
    logic [3:0]      r_bit_cnt;
    logic [PW-1:0]   r_ptr;
    logic [7:0]      r_rd_byte;
    logic            r_sda_oe, r_ack_pend, r_busy, r_wr_pulse;
    logic [PW-1:0]   r_wr_idx;
    logic [7:0]      r_regs [NREG];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
        end else begin
            r_scl_sync <= {r_scl_sync[0], scl_i};
            r_sda_sync <= {r_sda_sync[0], sda_i};
        end
    end

`ifdef I2C_SLV_GLITCH_FILTER_EN
    logic [2:0] r_scl_flt, r_sda_flt;
    logic       r_scl_hold, r_sda_hold;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_scl_flt  <= 3'b111;
            r_sda_flt  <= 3'b111;
            r_scl_hold <= 1'b1;
            r_sda_hold <= 1'b1;
        end else begin
            r_scl_flt  <= {r_scl_flt[1:0], r_scl_sync[1]};
            r_sda_flt  <= {r_sda_flt[1:0], r_sda_sync[1]};
            r_scl_hold <= w_scl_s;
            r_sda_hold <= w_sda_s;
        end
    end

    always_comb begin
        w_scl_s = r_scl_hold;
        w_sda_s = r_sda_hold;
        if (&r_scl_flt)       w_scl_s = 1'b1;
        else if (~|r_scl_flt) w_scl_s = 1'b0;
        if (&r_sda_flt)       w_sda_s = 1'b1;
        else if (~|r_sda_flt) w_sda_s = 1'b0;
    end
`else
    assign w_scl_s = r_scl_sync[1];
    assign w_sda_s = r_sda_sync[1];
`endif

    logic          w_scl_rise, w_scl_fall, w_start, w_stop;
    logic          w_last_bit, w_ack_slot, w_hit;
    logic [7:0]    w_byte;
    logic [PW-1:0] w_ptr_inc;

    assign w_scl_rise = w_scl_s & ~r_scl_d;
    assign w_scl_fall = ~w_scl_s & r_scl_d;
    assign w_start    = w_scl_s & r_scl_d & r_sda_d & ~w_sda_s;
    assign w_stop     = w_scl_s & r_scl_d & ~r_sda_d & w_sda_s;
    assign w_byte     = {r_shift, w_sda_s};
    assign w_hit      = (w_byte[7:1] == I2C_ADDR);
    assign w_last_bit = (r_bit_cnt == 4'd7);
    assign w_ack_slot = (r_bit_cnt == 4'd8);
    assign w_ptr_inc  = r_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_start) begin
            w_state_nxt = ST_ADDR;
        end else if (w_stop) begin
            w_state_nxt = ST_IDLE;
        end else if (w_scl_rise) begin
            case (r_state)
                ST_ADDR:  if (w_last_bit) w_state_nxt = !w_hit ? ST_IGNORE :
                                                        (w_byte[0] ? ST_RDATA : ST_PTR);
                ST_PTR:   if (w_last_bit) w_state_nxt = ST_WDATA;
                ST_RDATA: if (w_ack_slot && !r_ack_pend && w_sda_s) w_state_nxt = ST_IGNORE;
                default:  w_state_nxt = r_state;
            endcase
        end
    end

    // r_bit_cnt holds the index of the next bit to sample, so on a fall it names the bit starting.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_ptr      <= '0;
            r_rd_byte  <= '0;
            r_sda_oe   <= 1'b0;
            r_ack_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_wr_pulse <= 1'b0;
            r_wr_idx   <= '0;
            for (int k = 0; k < NREG; k++) r_regs[k] <= '0;
        end else begin
            r_scl_d    <= w_scl_s;
            r_sda_d    <= w_sda_s;
            r_wr_pulse <= 1'b0;
            if (w_start || w_stop) begin
                r_bit_cnt  <= '0;
                r_sda_oe   <= 1'b0;
                r_ack_pend <= 1'b0;
                r_busy     <= 1'b0;
            end else if (w_scl_rise) begin
                r_shift   <= w_byte[6:0];
                r_bit_cnt <= w_ack_slot ? 4'd0 : r_bit_cnt + 4'd1;
                if (w_ack_slot) r_ack_pend <= 1'b0;
                if (w_last_bit) begin
                    case (r_state)
                        ST_ADDR: if (w_hit) begin
                            r_ack_pend <= 1'b1;
                            r_busy     <= 1'b1;
                            if (w_byte[0]) r_rd_byte <= r_regs[r_ptr];
                        end
                        ST_PTR: begin
                            r_ack_pend <= 1'b1;
                            r_ptr      <= w_byte[PW-1:0];
                        end
                        ST_WDATA: begin
                            r_regs[r_ptr] <= w_byte;
                            r_wr_pulse    <= 1'b1;
                            r_wr_idx      <= r_ptr;
                            r_ptr         <= w_ptr_inc;
                            r_ack_pend    <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                if (r_state == ST_RDATA && w_ack_slot && !r_ack_pend && !w_sda_s) begin
                    r_ptr     <= w_ptr_inc;
                    r_rd_byte <= r_regs[w_ptr_inc];
                end
            end else if (w_scl_fall) begin
                if (w_ack_slot)                r_sda_oe <= r_ack_pend;
                else if (r_state == ST_RDATA)  r_sda_oe <= ~r_rd_byte[3'd7 - r_bit_cnt[2:0]];
                else                           r_sda_oe <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < NREG; k++) begin : g_flat
        assign regs_flat[8*k +: 8] = r_regs[k];
    end

    assign sda_oe   = r_sda_oe;
    assign wr_pulse = r_wr_pulse;
    assign wr_idx   = r_wr_idx;
    assign busy     = r_busy;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: bit-level I2C master, open-drain SDA, register-map reference model.
module tb_i2c_slave_regs;
    localparam int NREG = 8;
    localparam int Q    = 8;

    logic        clk = 1'b0, rst = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
    logic        sda_oe, wr_pulse, busy, sda_line;
    logic [63:0] regs_flat;
    logic [2:0]  wr_idx;

    assign sda_line = sda_m & ~sda_oe;
    always #5 clk = ~clk;

    i2c_slave_regs #(.I2C_ADDR(7'h57), .NREG(NREG)) dut (
        .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_line), .sda_oe(sda_oe),
        .regs_flat(regs_flat), .wr_pulse(wr_pulse), .wr_idx(wr_idx), .busy(busy)
    );

    int total = 0, bad = 0;
    int oe_rise = 0, oe_bad = 0, pw_bad = 0;
    logic prev_oe = 1'b0, prev_wp = 1'b0;
    logic [2:0] got_idx [$];
    int         exp_idx [$];
    logic [7:0] mdl_regs [NREG];
    int         mdl_ptr = 0;
    logic [7:0] dbuf [8];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (wr_pulse) got_idx.push_back(wr_idx);
            if (wr_pulse && prev_wp) pw_bad++;
            if (sda_oe && !prev_oe) begin
                oe_rise++;
                if (scl_m) oe_bad++;
            end
        end
        prev_oe = sda_oe;
        prev_wp = wr_pulse;
    end

    task automatic w(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; w(Q); scl_m = 1'b1; w(Q); sda_m = 1'b0; w(Q); scl_m = 1'b0; w(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; w(Q); scl_m = 1'b1; w(Q); sda_m = 1'b1; w(2*Q);
    endtask

    task automatic put_bit(input logic b, input bit glitch);
        sda_m = b; w(Q); scl_m = 1'b1;
        if (glitch) begin
            w(6); scl_m = 1'b0; w(2); scl_m = 1'b1; w(2*Q - 8);
        end else begin
            w(2*Q);
        end
        scl_m = 1'b0; w(Q);
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1'b1; w(Q); scl_m = 1'b1; w(Q); b = sda_line; w(Q); scl_m = 1'b0; w(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack, input int g);
        for (int i = 7; i >= 0; i--) put_bit(d[i], (7 - i) == g);
        get_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 0; i < 8; i++) begin
            get_bit(b);
            d = {d[6:0], b};
        end
        put_bit(nack, 1'b0);
    endtask

    function automatic logic [63:0] mdl_flat();
        logic [63:0] f;
        for (int k = 0; k < NREG; k++) f[8*k +: 8] = mdl_regs[k];
        return f;
    endfunction

    // What an unfiltered target captures when SCL sees one extra rise after bit g.
    function automatic logic [7:0] glitch_byte(input logic [7:0] d, input int g);
        logic bits [10];
        logic [7:0] r;
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            bits[n] = d[7-i]; n++;
            if (i == g) begin bits[n] = d[7-i]; n++; end
        end
        r = '0;
        for (int i = 0; i < 8; i++) r = {r[6:0], bits[i]};
        return r;
    endfunction

    task automatic check_state();
        chk("regs", regs_flat, mdl_flat());
        chk("npulse", got_idx.size(), exp_idx.size());
        for (int i = 0; i < exp_idx.size() && i < got_idx.size(); i++)
            chk("wr_idx", got_idx[i], exp_idx[i]);
        got_idx.delete();
        exp_idx.delete();
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] p, input int n);
        logic ack;
        bit hit;
        hit = (a == 7'h57);
        bus_start();
        write_byte({a, 1'b0}, ack, -1);
        chk("addr_ack", ack, !hit);
        chk("busy_addr", busy, hit);
        write_byte(p, ack, -1);
        chk("ptr_ack", ack, !hit);
        if (hit) mdl_ptr = int'(p) % NREG;
        for (int i = 0; i < n; i++) begin
            write_byte(dbuf[i], ack, -1);
            chk("data_ack", ack, !hit);
            if (hit) begin
                exp_idx.push_back(mdl_ptr);
                mdl_regs[mdl_ptr] = dbuf[i];
                mdl_ptr = (mdl_ptr + 1) % NREG;
            end
        end
        bus_stop();
        chk("busy_stop", busy, 1'b0);
        check_state();
    endtask

    task automatic do_read(input bit set_ptr, input logic [7:0] p, input int n);
        logic ack;
        logic [7:0] d;
        bus_start();
        if (set_ptr) begin
            write_byte(8'hAE, ack, -1); chk("rd_wadr_ack", ack, 1'b0);
            write_byte(p, ack, -1);     chk("rd_ptr_ack", ack, 1'b0);
            mdl_ptr = int'(p) % NREG;
            bus_start();
        end
        write_byte(8'hAF, ack, -1);
        chk("rd_addr_ack", ack, 1'b0);
        for (int i = 0; i < n; i++) begin
            read_byte(d, i == n - 1);
            chk("rd_data", d, mdl_regs[mdl_ptr]);
            if (i < n - 1) mdl_ptr = (mdl_ptr + 1) % NREG;
        end
        w(2);
        chk("oe_after_nack", sda_oe, 1'b0);
        bus_stop();
        check_state();
    endtask

    logic ack;
    logic [7:0] d, gexp;
    logic [6:0] ra;
    int oe0, kind, n;

    initial begin
        for (int k = 0; k < NREG; k++) mdl_regs[k] = '0;
        rst = 1'b0; w(4);
        chk("rst_oe", sda_oe, 1'b0);
        chk("rst_regs", regs_flat, 64'h0);
        chk("rst_wp", wr_pulse, 1'b0);
        chk("rst_idx", wr_idx, 3'd0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b1; w(4);

        dbuf[0] = 8'h11; dbuf[1] = 8'h22;
        do_write(7'h57, 8'h02, 2);

        dbuf[0] = 8'hA7; dbuf[1] = 8'hC0;
        do_write(7'h57, 8'h07, 2);
        do_read(1'b1, 8'h07, 2);

        oe0 = oe_rise;
        dbuf[0] = 8'h55;
        do_write(7'h48, 8'h01, 1);
        chk("mis_oe", oe_rise - oe0, 0);

        bus_start();
        write_byte(8'hAE, ack, -1);
        write_byte(8'h01, ack, -1);
        mdl_ptr = 1;
        for (int i = 0; i < 4; i++) put_bit(1'b1, 1'b0);
        bus_stop();
        check_state();
        dbuf[0] = 8'h05;
        do_write(7'h57, 8'h01, 1);
        chk("abort_reg1", regs_flat[15:8], 8'h05);

        dbuf[0] = 8'h3C;
        do_write(7'h57, 8'h04, 1);
        bus_start();
        write_byte(8'hAE, ack, -1);
        write_byte(8'h04, ack, -1);
        mdl_ptr = 4;
        bus_start();
        write_byte(8'hAF, ack, -1);
        chk("oe_pre_rst", sda_oe, !mdl_regs[mdl_ptr][7]);
        rst = 1'b0; w(1);
        chk("oe_rst", sda_oe, 1'b0);
        chk("regs_rst", regs_flat, 64'h0);
        w(1); rst = 1'b1;
        for (int k = 0; k < NREG; k++) mdl_regs[k] = '0;
        mdl_ptr = 0;
        oe0 = oe_rise;
        read_byte(d, 1'b1);
        bus_stop();
        chk("oe_ignored", oe_rise - oe0, 0);
        check_state();

        bus_start();
        write_byte(8'hAE, ack, -1);
        write_byte(8'h06, ack, -1);
        write_byte(8'hB4, ack, 3);
`ifdef I2C_SLV_GLITCH_FILTER_EN
        gexp = 8'hB4;
        chk("glitch_ack", ack, 1'b0);
`else
        gexp = glitch_byte(8'hB4, 3);
`endif
        bus_stop();
        mdl_regs[6] = gexp;
        exp_idx.push_back(6);
        mdl_ptr = 7;
        check_state();

        for (int it = 0; it < 12; it++) begin
            kind = $urandom_range(0, 3);
            if (kind <= 1) begin
                n = $urandom_range(0, 4);
                for (int i = 0; i < n; i++) dbuf[i] = 8'($urandom);
                ra = 7'h57;
                if ($urandom_range(0, 4) == 0) begin
                    ra = 7'($urandom_range(0, 127));
                    if (ra == 7'h57) ra = 7'h10;
                end
                do_write(ra, 8'($urandom_range(0, 255)), n);
            end else begin
                do_read(kind == 3, 8'($urandom_range(0, 255)), $urandom_range(1, 4));
            end
        end

        chk("pulse_width", pw_bad, 0);
        chk("oe_while_scl_high", oe_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
